// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for the ripple counter monitor.
package ripple_mon_pkg;

   localparam int DEF_WIDTH = 4;
   localparam logic [DEF_WIDTH-1:0] MAX = {DEF_WIDTH{1'b1}};
   localparam logic [15:0] STEPS_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } mon_state_t;

endpackage

// File: rtl/cdc_bus_sync.sv
// Multi-flop synchroniser for a bus sampled from another clock domain.
module cdc_bus_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] chain_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_reg <= '0;
      end else begin
         chain_reg[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain_reg[i] <= chain_reg[i-1];
         end
      end
   end

   assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/ripple_count_monitor.sv
// Samples an asynchronous ripple counter, filters transients and classifies
// each settled change as an up/down step, a wrap, or an illegal jump.
module ripple_count_monitor
   import ripple_mon_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] count_out,
   output logic             count_valid,
   output logic             dir,
   output logic             step,
   output logic             wrap,
   output logic             jump_err,
   output logic             err_sticky,
   output logic [15:0]      steps_seen
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] DIFF_UP = WIDTH'(1);

   logic [WIDTH-1:0] s_cnt;
   logic [WIDTH-1:0] prev_reg;
   logic [SW-1:0]    stab_reg, stab_next;
   logic             accept;
   logic             active;

   mon_state_t       state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             valid_reg, valid_next;
   logic             dir_reg, dir_next;
   logic             step_reg, step_next;
   logic             wrap_reg, wrap_next;
   logic             jump_reg, jump_next;
   logic             sticky_reg, sticky_next;
   logic [15:0]      steps_reg, steps_next;
   logic [WIDTH-1:0] diff;

   cdc_bus_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cnt_in),
      .q     (s_cnt)
   );

   // Filter is held cleared while idle so the current value is re-acquired after enable.
   assign active = en && (state_reg != IDLE);

   always_comb begin
      stab_next = stab_reg;
      accept    = 1'b0;
      if (!active) begin
         stab_next = '0;
      end else if (s_cnt != prev_reg) begin
         stab_next = SW'(1);
      end else if (stab_reg < STAB_MAX) begin
         stab_next = stab_reg + SW'(1);
      end
      accept = active && (stab_next == STAB_MAX) &&
               ((s_cnt != prev_reg) || (stab_reg != STAB_MAX));
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      valid_next  = valid_reg;
      dir_next    = dir_reg;
      step_next   = 1'b0;
      wrap_next   = 1'b0;
      jump_next   = 1'b0;
      sticky_next = sticky_reg;
      steps_next  = steps_reg;
      diff        = s_cnt - count_reg;

      if (!en) begin
         state_next  = IDLE;
         valid_next  = 1'b0;
         sticky_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = ACQUIRE;
            end
            ACQUIRE: begin
               if (accept) begin
                  count_next = s_cnt;
                  valid_next = 1'b1;
                  state_next = TRACK;
               end
            end
            TRACK: begin
               if (accept && (s_cnt != count_reg)) begin
                  count_next = s_cnt;
                  if (diff == DIFF_UP) begin
                     dir_next  = 1'b1;
                     step_next = 1'b1;
                     wrap_next = (count_reg == CNT_MAX);
                  end else if (diff == CNT_MAX) begin
                     dir_next  = 1'b0;
                     step_next = 1'b1;
                     wrap_next = (count_reg == '0);
                  end else begin
                     jump_next   = 1'b1;
                     sticky_next = 1'b1;
                  end
                  if (step_next && (steps_reg != STEPS_MAX)) begin
                     steps_next = steps_reg + 16'd1;
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg   <= '0;
         stab_reg   <= '0;
         state_reg  <= IDLE;
         count_reg  <= '0;
         valid_reg  <= 1'b0;
         dir_reg    <= 1'b0;
         step_reg   <= 1'b0;
         wrap_reg   <= 1'b0;
         jump_reg   <= 1'b0;
         sticky_reg <= 1'b0;
         steps_reg  <= '0;
      end else begin
         prev_reg   <= s_cnt;
         stab_reg   <= stab_next;
         state_reg  <= state_next;
         count_reg  <= count_next;
         valid_reg  <= valid_next;
         dir_reg    <= dir_next;
         step_reg   <= step_next;
         wrap_reg   <= wrap_next;
         jump_reg   <= jump_next;
         sticky_reg <= sticky_next;
         steps_reg  <= steps_next;
      end
   end

   assign count_out   = count_reg;
   assign count_valid = valid_reg;
   assign dir         = dir_reg;
   assign step        = step_reg;
   assign wrap        = wrap_reg;
   assign jump_err    = jump_reg;
   assign err_sticky  = sticky_reg;
   assign steps_seen  = steps_reg;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Randomized self-checking bench for ripple_count_monitor against a
// transaction-level model of settled counter values.
module tb_ripple_count_monitor;

   localparam int HOLD = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  cnt_in;
   logic [3:0]  count_out;
   logic        count_valid;
   logic        dir;
   logic        step;
   logic        wrap;
   logic        jump_err;
   logic        err_sticky;
   logic [15:0] steps_seen;

   int n_checks = 0;
   int n_fail   = 0;

   // Pulse tallies over the current transaction window.
   int step_seen, wrap_seen, jump_seen, ovl_seen;

   // Model of the settled-value history.
   bit       m_valid;
   int       m_cnt;
   bit       m_dir;
   int       m_steps;
   bit       m_sticky;

   ripple_count_monitor dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cnt_in      (cnt_in),
      .count_out   (count_out),
      .count_valid (count_valid),
      .dir         (dir),
      .step        (step),
      .wrap        (wrap),
      .jump_err    (jump_err),
      .err_sticky  (err_sticky),
      .steps_seen  (steps_seen)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (step) step_seen++;
      if (wrap) wrap_seen++;
      if (jump_err) jump_seen++;
      if (jump_err && (step || wrap)) ovl_seen++;
      if (wrap && !step) ovl_seen++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count_out"},   int'(count_out),   m_cnt);
      check({tag, ".count_valid"}, int'(count_valid), int'(m_valid));
      check({tag, ".dir"},         int'(dir),         int'(m_dir));
      check({tag, ".steps_seen"},  int'(steps_seen),  m_steps);
      check({tag, ".err_sticky"},  int'(err_sticky),  int'(m_sticky));
   endtask

   // Present one settled value (optionally preceded by a one-cycle transient)
   // and compare the monitor's reaction with the model.
   task automatic apply(input string tag, input int tgt, input bit glitch, input int tr);
      int exp_step, exp_wrap, exp_jump, d;
      @(negedge clk);
      step_seen = 0; wrap_seen = 0; jump_seen = 0; ovl_seen = 0;
      if (glitch) begin
         cnt_in = 4'(tr);
         @(negedge clk);
      end
      cnt_in = 4'(tgt);
      repeat (HOLD) @(negedge clk);

      exp_step = 0; exp_wrap = 0; exp_jump = 0;
      if (!m_valid) begin
         m_valid = 1'b1;
         m_cnt   = tgt;
      end else if (tgt != m_cnt) begin
         d = (tgt - m_cnt + 16) % 16;
         if (d == 1) begin
            exp_step = 1;
            exp_wrap = (m_cnt == 15);
            m_dir    = 1'b1;
            if (m_steps < 65535) m_steps++;
         end else if (d == 15) begin
            exp_step = 1;
            exp_wrap = (m_cnt == 0);
            m_dir    = 1'b0;
            if (m_steps < 65535) m_steps++;
         end else begin
            exp_jump = 1;
            m_sticky = 1'b1;
         end
         m_cnt = tgt;
      end
      $display("txn %s: target=%0d glitch=%0d step=%0d wrap=%0d jump=%0d count_out=%0d steps=%0d",
               tag, tgt, glitch, step_seen, wrap_seen, jump_seen, count_out, steps_seen);
      check({tag, ".step_pulses"}, step_seen, exp_step);
      check({tag, ".wrap_pulses"}, wrap_seen, exp_wrap);
      check({tag, ".jump_pulses"}, jump_seen, exp_jump);
      check({tag, ".overlap"},     ovl_seen,  0);
      check_state(tag);
   endtask

   initial begin
      int v, r;
      rst_n = 1'b0; en = 1'b0; cnt_in = 4'd0;
      m_valid = 1'b0; m_cnt = 0; m_dir = 1'b0; m_steps = 0; m_sticky = 1'b0;
      repeat (3) @(negedge clk);
      check_state("reset");
      check("reset.step", int'(step), 0);
      rst_n = 1'b1;

      // First acquisition latency: count_valid rises on the 4th edge.
      @(negedge clk);
      en = 1'b1; cnt_in = 4'd3;
      repeat (3) @(posedge clk);
      #1 check("acq.valid_early", int'(count_valid), 0);
      @(posedge clk);
      #1;
      check("acq.valid", int'(count_valid), 1);
      check("acq.count", int'(count_out), 3);
      check("acq.step", int'(step), 0);
      check("acq.jump", int'(jump_err), 0);
      $display("txn acquire: count_out=%0d valid=%0d", count_out, count_valid);
      m_valid = 1'b1; m_cnt = 3;

      for (int i = 4; i <= 16; i++) apply("up", i % 16, 1'b0, 0);
      check("up.steps_total", int'(steps_seen), 13);
      check("up.dir", int'(dir), 1);

      apply("up2", 1, 1'b0, 0);
      apply("up3", 2, 1'b0, 0);
      apply("down", 1, 1'b0, 0);
      apply("down", 0, 1'b0, 0);
      apply("down_wrap", 15, 1'b0, 0);

      apply("to7", 7, 1'b0, 0);
      apply("glitch_jump", 4, 1'b1, 6);
      apply("back7", 7, 1'b0, 0);
      apply("clean_carry", 8, 1'b1, 6);

      // Asynchronous reset between edges clears everything at once.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_cnt = 0; m_dir = 1'b0; m_steps = 0; m_sticky = 1'b0;
      check_state("midreset");
      check("midreset.step", int'(step), 0);
      @(negedge clk);
      rst_n = 1'b1;
      apply("reacq", 8, 1'b0, 0);
      apply("step9", 9, 1'b0, 0);
      apply("jump", 2, 1'b0, 0);

      // Disable, move the counter while idle, then re-enable.
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      m_valid = 1'b0; m_sticky = 1'b0;
      check_state("disabled");
      cnt_in = 4'd9;
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1 check("reen.valid_early", int'(count_valid), 0);
      apply("reen", 9, 1'b0, 0);

      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      v = ($urandom_range(0, 1) != 0) ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
         else if (r < 70) v = m_cnt;
         else             v = $urandom_range(0, 15);
         apply("rand", v, ($urandom_range(0, 5) == 0), $urandom_range(0, 15));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
